// File: rtl/clint_axi_pkg.sv
// Shared definitions for the CLINT AXI4-Lite initiator: FSM states, AXI
// response codes and CLINT register offsets.
package clint_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WB,
        ST_RD,
        ST_RR,
        ST_RESP
    } state_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [63:0] CLINT_MSIP_OFFSET     = 64'h0000_0000_0000_0000;
    localparam logic [63:0] CLINT_MTIMECMP_OFFSET = 64'h0000_0000_0000_4000;
    localparam logic [63:0] CLINT_MTIME_OFFSET    = 64'h0000_0000_0000_BFF8;

    // SLVERR and DECERR both carry bit 1
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/clint_axi_timeout_cnt.sv
// Saturating wait counter: counts while enabled, clears when disabled, and
// pulses hit_o on the cycle the count reaches MAX (MAX = 0 disables).
module clint_axi_timeout_cnt #(
    parameter int unsigned MAX = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic hit_o
);

    localparam int unsigned CW = (MAX > 0) ? $clog2(MAX + 1) : 1;
    localparam logic [CW-1:0] LAST = (MAX > 0) ? CW'(MAX - 1) : '0;
    localparam logic [CW-1:0] SAT  = CW'(MAX);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i) begin
            cnt_d = '0;
        end else if (cnt_q != SAT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // hit fires once: the count then sits at SAT, which never equals LAST
    assign hit_o = (MAX != 0) && en_i && (cnt_q == LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/clint_axi_initiator.sv
// Single-outstanding AXI4-Lite master turning a command/response port into
// CLINT register reads and writes.
module clint_axi_initiator
    import clint_axi_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_we,
    input  logic [AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                          rsp_valid,
    output logic [AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic                          rsp_err,
    output logic                          rsp_timeout,
    output logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    input  logic [1:0]                    m_axi_bresp,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready,
    output logic [AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready
);

    state_e                        state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0]     addr_q;
    logic [AXI_DATA_WIDTH-1:0]     wdata_q;
    logic [AXI_DATA_WIDTH/8-1:0]   wstrb_q;
    logic [AXI_DATA_WIDTH-1:0]     rdata_q, rdata_d;
    logic                          aw_done_q, aw_done_d;
    logic                          w_done_q, w_done_d;
    logic                          err_q, err_d;
    logic                          tmo_q, tmo_d;
    logic                          accept;
    logic                          wait_en;
    logic                          tmo_hit;

    assign accept  = cmd_valid && cmd_ready;
    assign wait_en = (state_q == ST_WB) || (state_q == ST_RR);

    clint_axi_timeout_cnt #(
        .MAX (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk_i  (aclk),
        .rst_ni (aresetn),
        .en_i   (wait_en),
        .hit_o  (tmo_hit)
    );

    always_comb begin
        state_d       = state_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        rdata_d       = rdata_q;
        err_d         = err_q;
        tmo_d         = tmo_q;
        cmd_ready     = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        rsp_valid     = 1'b0;

        if (tmo_hit) begin
            tmo_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                // gated so cmd_ready reads 0 while reset is held
                cmd_ready = aresetn;
                if (cmd_valid) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    tmo_d     = 1'b0;
                    state_d   = cmd_we ? ST_WR : ST_RD;
                end
            end
            ST_WR: begin
                m_axi_awvalid = !aw_done_q;
                m_axi_wvalid  = !w_done_q;
                aw_done_d     = aw_done_q || m_axi_awready;
                w_done_d      = w_done_q || m_axi_wready;
                if (aw_done_d && w_done_d) begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) begin
                    rdata_d = '0;
                    err_d   = resp_is_err(m_axi_bresp);
                    state_d = ST_RESP;
                end
            end
            ST_RD: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) begin
                    state_d = ST_RR;
                end
            end
            ST_RR: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid) begin
                    rdata_d = m_axi_rdata;
                    err_d   = resp_is_err(m_axi_rresp);
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rdata_q   <= rdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
            if (accept) begin
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                wstrb_q <= cmd_wstrb;
            end
        end
    end

    assign m_axi_awaddr = addr_q;
    assign m_axi_araddr = addr_q;
    assign m_axi_wdata  = wdata_q;
    assign m_axi_wstrb  = wstrb_q;
    assign rsp_rdata    = rdata_q;
    assign rsp_err      = err_q;
    assign rsp_timeout  = tmo_q;

endmodule

// File: tb/tb_clint_axi_initiator.sv
// Directed bench for clint_axi_initiator: configurable AXI-Lite slave,
// protocol monitor and response scoreboard.
module tb_clint_axi_initiator;
    import clint_axi_pkg::*;

    localparam int unsigned AW  = 64;
    localparam int unsigned DW  = 64;
    localparam int unsigned TMO = 16;

    logic            aclk;
    logic            aresetn;
    logic            cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0]   cmd_addr;
    logic [DW-1:0]   cmd_wdata;
    logic [DW/8-1:0] cmd_wstrb;
    logic            rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err, rsp_timeout;
    logic [AW-1:0]   m_axi_awaddr;
    logic            m_axi_awvalid, m_axi_awready;
    logic [DW-1:0]   m_axi_wdata;
    logic [DW/8-1:0] m_axi_wstrb;
    logic            m_axi_wvalid, m_axi_wready;
    logic [1:0]      m_axi_bresp;
    logic            m_axi_bvalid, m_axi_bready;
    logic [AW-1:0]   m_axi_araddr;
    logic            m_axi_arvalid, m_axi_arready;
    logic [DW-1:0]   m_axi_rdata;
    logic [1:0]      m_axi_rresp;
    logic            m_axi_rvalid, m_axi_rready;

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
        logic        tmo;
    } exp_t;

    exp_t        sb[$];
    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned cyc = 0;

    int unsigned aw_dly, w_dly, ar_dly, r_dly, b_dly;
    logic [1:0]  b_resp_cfg, r_resp_cfg;
    logic [63:0] r_data_cfg;
    logic        lat_mode, tmo_test;
    logic [63:0] exp_addr, exp_wdata;
    logic [7:0]  exp_wstrb;
    int unsigned acc_cyc, aw_hs_cyc, w_hs_cyc, ar_hs_cyc, rr_idx;
    logic        acc_we, aw_seen, w_seen;

    clint_axi_initiator #(
        .AXI_ADDR_WIDTH (AW),
        .AXI_DATA_WIDTH (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_we        (cmd_we),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .cmd_wstrb     (cmd_wstrb),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .rsp_timeout   (rsp_timeout),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Slave: each ready/valid rises after its configured number of cycles
    initial begin : slave_aw
        int unsigned n;
        n = 0;
        m_axi_awready = 1'b0;
        forever begin
            @(negedge aclk);
            if (!aresetn || !m_axi_awvalid) begin
                m_axi_awready = 1'b0;
                n = 0;
            end else if (n >= aw_dly) m_axi_awready = 1'b1;
            else n++;
        end
    end

    initial begin : slave_w
        int unsigned n;
        n = 0;
        m_axi_wready = 1'b0;
        forever begin
            @(negedge aclk);
            if (!aresetn || !m_axi_wvalid) begin
                m_axi_wready = 1'b0;
                n = 0;
            end else if (n >= w_dly) m_axi_wready = 1'b1;
            else n++;
        end
    end

    initial begin : slave_ar
        int unsigned n;
        n = 0;
        m_axi_arready = 1'b0;
        forever begin
            @(negedge aclk);
            if (!aresetn || !m_axi_arvalid) begin
                m_axi_arready = 1'b0;
                n = 0;
            end else if (n >= ar_dly) m_axi_arready = 1'b1;
            else n++;
        end
    end

    initial begin : slave_b
        int unsigned n;
        n = 0;
        m_axi_bvalid = 1'b0;
        m_axi_bresp  = 2'b00;
        forever begin
            @(negedge aclk);
            if (!aresetn || !m_axi_bready) begin
                m_axi_bvalid = 1'b0;
                n = 0;
            end else if (n >= b_dly) begin
                m_axi_bvalid = 1'b1;
                m_axi_bresp  = b_resp_cfg;
            end else n++;
        end
    end

    initial begin : slave_r
        int unsigned n;
        n = 0;
        m_axi_rvalid = 1'b0;
        m_axi_rresp  = 2'b00;
        m_axi_rdata  = '0;
        forever begin
            @(negedge aclk);
            if (!aresetn || !m_axi_rready) begin
                m_axi_rvalid = 1'b0;
                n = 0;
            end else if (n >= r_dly) begin
                m_axi_rvalid = 1'b1;
                m_axi_rresp  = r_resp_cfg;
                m_axi_rdata  = r_data_cfg;
            end else n++;
        end
    end

    initial begin : monitor
        logic p_aw_pend, p_w_pend, p_ar_pend, p_aw_hs, p_w_hs, p_ar_hs, p_rsp;
        logic [AW-1:0] p_awaddr, p_araddr;
        logic [DW-1:0] p_wdata;
        exp_t e;
        {p_aw_pend, p_w_pend, p_ar_pend, p_aw_hs, p_w_hs, p_ar_hs, p_rsp} = '0;
        p_awaddr = '0;
        p_araddr = '0;
        p_wdata  = '0;
        forever begin
            @(negedge aclk);
            #1;
            if (!aresetn) begin
                {p_aw_pend, p_w_pend, p_ar_pend, p_aw_hs, p_w_hs, p_ar_hs, p_rsp} = '0;
                aw_seen = 1'b0;
                w_seen  = 1'b0;
            end else begin
                if (cmd_valid && cmd_ready) begin
                    acc_cyc = cyc + 1;
                    acc_we  = cmd_we;
                    aw_seen = 1'b0;
                    w_seen  = 1'b0;
                    rr_idx  = 0;
                end
                if (p_aw_pend) begin
                    check("awvalid_hold", m_axi_awvalid, 1);
                    check("awaddr_hold", m_axi_awaddr, p_awaddr);
                end
                if (p_w_pend) begin
                    check("wvalid_hold", m_axi_wvalid, 1);
                    check("wdata_hold", m_axi_wdata, p_wdata);
                end
                if (p_ar_pend) begin
                    check("arvalid_hold", m_axi_arvalid, 1);
                    check("araddr_hold", m_axi_araddr, p_araddr);
                end
                if (p_aw_hs) check("awvalid_drop", m_axi_awvalid, 0);
                if (p_w_hs)  check("wvalid_drop", m_axi_wvalid, 0);
                if (p_ar_hs) check("arvalid_drop", m_axi_arvalid, 0);
                if (m_axi_awvalid && m_axi_awready) begin
                    aw_seen   = 1'b1;
                    aw_hs_cyc = cyc + 1;
                    check("awaddr", m_axi_awaddr, exp_addr);
                end
                if (m_axi_wvalid && m_axi_wready) begin
                    w_seen   = 1'b1;
                    w_hs_cyc = cyc + 1;
                    check("wdata", m_axi_wdata, exp_wdata);
                    check("wstrb", m_axi_wstrb, exp_wstrb);
                end
                if (m_axi_arvalid && m_axi_arready) begin
                    ar_hs_cyc = cyc + 1;
                    check("araddr", m_axi_araddr, exp_addr);
                end
                if (m_axi_bvalid) begin
                    check("b_beat_accepted", m_axi_bready, 1);
                    if (m_axi_bready) check("b_after_aw_w", {aw_seen, w_seen}, 2'b11);
                end
                if (m_axi_rvalid) check("r_beat_accepted", m_axi_rready, 1);
                if (m_axi_rready) begin
                    if (tmo_test && rr_idx == 15) check("tmo_low_rr15", rsp_timeout, 0);
                    if (tmo_test && rr_idx == 16) check("tmo_set_rr16", rsp_timeout, 1);
                    rr_idx++;
                end
                if (p_rsp) begin
                    check("rsp_one_cycle", rsp_valid, 0);
                    check("cmd_ready_after_rsp", cmd_ready, 1);
                end
                if (rsp_valid) begin
                    check("rsp_expected", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("rsp_rdata", rsp_rdata, e.rdata);
                        check("rsp_err", rsp_err, e.err);
                        check("rsp_timeout", rsp_timeout, e.tmo);
                    end
                    check("cmd_ready_in_resp", cmd_ready, 0);
                    if (lat_mode) begin
                        check("rsp_latency", (cyc + 1) - acc_cyc, 3);
                        if (acc_we) begin
                            check("aw_latency", aw_hs_cyc - acc_cyc, 1);
                            check("w_latency", w_hs_cyc - acc_cyc, 1);
                        end else begin
                            check("ar_latency", ar_hs_cyc - acc_cyc, 1);
                        end
                    end
                end
                p_aw_pend = m_axi_awvalid && !m_axi_awready;
                p_w_pend  = m_axi_wvalid && !m_axi_wready;
                p_ar_pend = m_axi_arvalid && !m_axi_arready;
                p_aw_hs   = m_axi_awvalid && m_axi_awready;
                p_w_hs    = m_axi_wvalid && m_axi_wready;
                p_ar_hs   = m_axi_arvalid && m_axi_arready;
                p_awaddr  = m_axi_awaddr;
                p_araddr  = m_axi_araddr;
                p_wdata   = m_axi_wdata;
                p_rsp     = rsp_valid;
            end
        end
    end

    task automatic issue(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [7:0] strb, input logic tmo_exp);
        exp_t e;
        int unsigned n;
        n = 0;
        e.rdata   = we ? 64'h0 : r_data_cfg;
        e.err     = we ? b_resp_cfg[1] : r_resp_cfg[1];
        e.tmo     = tmo_exp;
        exp_addr  = addr;
        exp_wdata = wdata;
        exp_wstrb = strb;
        @(negedge aclk);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_wstrb = strb;
        while (!cmd_ready && n < 100) begin
            @(negedge aclk);
            n++;
        end
        check("cmd_accepted", n < 100, 1);
        sb.push_back(e);
        @(negedge aclk);
        cmd_valid = 1'b0;
        cmd_wdata = '0;
    endtask

    task automatic wait_done(input int unsigned limit);
        int unsigned n;
        n = 0;
        while (sb.size() != 0 && n < limit) begin
            @(negedge aclk);
            n++;
        end
        #2;
        check("rsp_arrived", sb.size(), 0);
        repeat (3) @(negedge aclk);
    endtask

    initial begin : stimulus
        aresetn    = 1'b0;
        cmd_valid  = 1'b0;
        cmd_we     = 1'b0;
        cmd_addr   = '0;
        cmd_wdata  = '0;
        cmd_wstrb  = '0;
        aw_dly = 0; w_dly = 0; ar_dly = 0; r_dly = 0; b_dly = 0;
        b_resp_cfg = AXI_RESP_OKAY;
        r_resp_cfg = AXI_RESP_OKAY;
        r_data_cfg = 64'h0;
        lat_mode   = 1'b0;
        tmo_test   = 1'b0;
        exp_addr = '0; exp_wdata = '0; exp_wstrb = '0;
        acc_cyc = 0; aw_hs_cyc = 0; w_hs_cyc = 0; ar_hs_cyc = 0; rr_idx = 0;
        acc_we = 1'b0; aw_seen = 1'b0; w_seen = 1'b0;

        repeat (3) @(negedge aclk);
        check("rst_ctrl", {cmd_ready, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready,
                           m_axi_rready, rsp_valid, rsp_err, rsp_timeout}, 9'h0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_addr", m_axi_awaddr, 0);
        aresetn = 1'b1;
        @(negedge aclk);
        check("idle_cmd_ready", cmd_ready, 1);

        // zero-wait write and read with latency checks
        lat_mode = 1'b1;
        issue(1'b1, CLINT_MTIMECMP_OFFSET, 64'h1234, 8'hFF, 1'b0);
        wait_done(50);
        r_data_cfg = 64'h0123_4567_89AB_CDEF;
        issue(1'b0, CLINT_MSIP_OFFSET, 64'h0, 8'h00, 1'b0);
        wait_done(50);
        lat_mode = 1'b0;

        // read with wait states
        ar_dly = 3; r_dly = 5; r_data_cfg = 64'hDEAD_BEEF;
        issue(1'b0, CLINT_MTIME_OFFSET, 64'h0, 8'h00, 1'b0);
        wait_done(50);
        ar_dly = 0; r_dly = 0;

        // skewed write channels, both orders
        aw_dly = 4; w_dly = 0;
        issue(1'b1, CLINT_MSIP_OFFSET, 64'h1, 8'h0F, 1'b0);
        wait_done(50);
        check("skew_w_first", aw_hs_cyc - w_hs_cyc, 4);
        aw_dly = 0; w_dly = 4;
        issue(1'b1, CLINT_MTIMECMP_OFFSET, 64'hA5A5_0000_FFFF_5A5A, 8'hF0, 1'b0);
        wait_done(50);
        check("skew_aw_first", w_hs_cyc - aw_hs_cyc, 4);
        w_dly = 0;

        // error responses
        b_resp_cfg = AXI_RESP_SLVERR;
        issue(1'b1, CLINT_MSIP_OFFSET, 64'h1, 8'h01, 1'b0);
        wait_done(50);
        b_resp_cfg = AXI_RESP_OKAY;
        r_resp_cfg = AXI_RESP_DECERR; r_data_cfg = 64'h5555;
        issue(1'b0, CLINT_MTIME_OFFSET, 64'h0, 8'h00, 1'b0);
        wait_done(50);
        r_resp_cfg = AXI_RESP_OKAY;

        // timeout: R withheld for 20 cycles, flag sticky until next command
        tmo_test = 1'b1; r_dly = 20; r_data_cfg = 64'hCAFE;
        issue(1'b0, CLINT_MTIME_OFFSET, 64'h0, 8'h00, 1'b1);
        wait_done(100);
        tmo_test = 1'b0; r_dly = 0;
        check("tmo_sticky", rsp_timeout, 1);
        r_data_cfg = 64'hBEEF;
        issue(1'b0, CLINT_MSIP_OFFSET, 64'h0, 8'h00, 1'b0);
        #1;
        check("tmo_clear_on_accept", rsp_timeout, 0);
        wait_done(50);

        // reset while AW and W are both stalled
        aw_dly = 50; w_dly = 50;
        issue(1'b1, CLINT_MTIMECMP_OFFSET, 64'h77, 8'hFF, 1'b0);
        begin
            int unsigned n;
            n = 0;
            while (!m_axi_awvalid && n < 20) begin
                @(negedge aclk);
                n++;
            end
        end
        check("pre_rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_awready}, 3'b110);
        aresetn = 1'b0;
        #1;
        check("rst_mid_valids", {m_axi_awvalid, m_axi_wvalid}, 2'b00);
        sb.delete();
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        aw_dly = 0; w_dly = 0;
        @(negedge aclk);
        check("post_rst_cmd_ready", cmd_ready, 1);
        r_data_cfg = 64'h600D_F00D;
        issue(1'b0, CLINT_MTIME_OFFSET, 64'h0, 8'h00, 1'b0);
        wait_done(50);

        check("sb_empty_end", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog observed=time_limit_reached expected=finish checks=%0d failures=%0d",
                 checks, failures + 1);
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/clint_axi_initiator.md
Name: clint_axi_initiator

Overview:
- Single-outstanding AXI4-Lite master that turns a simple command/response port into register reads/writes on the CLINT slave (msip, mtimecmp, mtime).
- Sits between a local control agent (boot ROM sequencer, debug bridge) and the interconnect port that feeds the CLINT wrapper.
- Uses flat Xilinx-style m_axi_* signal naming.

Parameters:
AXI_ADDR_WIDTH, 64, address width of command and AW/AR channels
AXI_DATA_WIDTH, 64, data width; strobe width is AXI_DATA_WIDTH/8
TIMEOUT_CYCLES, 1024, cycles without B/R before rsp_timeout asserts (0 disables)

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
cmd_valid/cmd_ready  in/out  1/1  command handshake
cmd_we  in  1  1 = write, 0 = read
cmd_addr  in  AXI_ADDR_WIDTH  byte address
cmd_wdata/cmd_wstrb  in  DW/DW/8  write data and strobes (ignored for reads)
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DW  read data (0 for writes)
rsp_err  out  1  BRESP/RRESP[1] set (SLVERR/DECERR)
rsp_timeout  out  1  sticky; cleared by next accepted command
m_axi_awaddr/awvalid/awready  out/out/in  AW/1/1  write-address channel
m_axi_wdata/wstrb/wvalid/wready  out/out/out/in  DW/DW/8/1/1  write-data channel
m_axi_bresp/bvalid/bready  in/in/out  2/1/1  write-response channel
m_axi_araddr/arvalid/arready  out/out/in  AW/1/1  read-address channel
m_axi_rdata/rresp/rvalid/rready  in/in/in/out  DW/2/1/1  read-data channel

Behaviour:
- Reset: all valid/ready outputs 0; rsp_rdata, rsp_err, rsp_timeout 0; addr/data regs 0; state IDLE.
- States:
  - IDLE: cmd_ready=1. Command accepted on cmd_valid&&cmd_ready; addr/data/strb registered. Write -> WR, read -> RD.
  - WR: awvalid and wvalid both asserted next cycle. Per-channel done flags aw_done/w_done; each valid drops the cycle after its own handshake, in either order or the same cycle. Both done -> WB.
  - WB: bready=1. On bvalid -> RESP.
  - RD: arvalid until arready -> RR.
  - RR: rready=1. On rvalid, capture rdata -> RESP.
  - RESP: rsp_valid=1 for exactly one cycle; rsp_err=resp[1] -> IDLE.
- cmd_ready is 0 in every state except IDLE.
- Min latency, zero-wait slave:
  - Write: accept C, AW/W C+1, B C+2, rsp_valid C+3.
  - Read: AR C+1, R C+2, rsp_valid C+3.
- Valid stability: once asserted, awvalid/wvalid/arvalid and their payloads hold until handshake. Never wait for ready before asserting valid.
- bready/rready asserted only in WB/RR. B/R beats arriving in other states are protocol violations; the bench treats them as an assertion failure.
- Timeout: counter runs in WB/RR. Reaching TIMEOUT_CYCLES sets rsp_timeout. The FSM keeps waiting; the AXI transaction is never abandoned. Counter saturates and clears on state exit.
- Reset mid-transaction: all valids drop asynchronously and the FSM returns to IDLE. The downstream slave is expected to be reset by the same aresetn.
- Address is passed unmodified; no alignment check. Write responses return rsp_rdata=0.

Decomposition:
- Shared package clint_axi_pkg: state enum, AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR constants, CLINT register offsets (MSIP 0x0, MTIMECMP 0x4000, MTIME 0xBFF8) for users and bench.
- One optional sub-module, clint_axi_timeout_cnt: saturating counter with enable/clear/hit.
- Otherwise a single flat FSM.

Test Plan:
- Write: cmd_we=1, addr 0x4000, wdata 0x1234, wstrb 0xFF, slave ready always. -> AW/W at C+1, rsp_valid at C+3, rsp_err=0, single pulse.
- Read with wait states: addr 0xBFF8, arready delayed 3 cycles, rvalid delayed 5 cycles, rdata 0xDEAD_BEEF. -> araddr stable throughout, rsp_rdata=0xDEADBEEF, rsp_valid exactly once.
- Skewed write channels: wready 4 cycles before awready, then the reverse order. -> each valid drops right after its own handshake; B accepted only after both; one response.
- Error: bresp=2'b10 on write, then rresp=2'b11 on read. -> rsp_err=1 both times; cmd_ready returns 1 the cycle after rsp_valid.
- Timeout: TIMEOUT_CYCLES=16, slave withholds rvalid for 20 cycles. -> rsp_timeout=1 at cycle 16 of RR; rsp_valid at R arrival; rsp_timeout clears on next accepted command.
- Reset mid-write: deassert aresetn while awvalid=1 and awready=0. -> awvalid/wvalid=0 immediately; after release, cmd_ready=1 and a new read completes normally.
